// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
// Shared types and helpers for the UART frame controller:
//   frame_state_e  - frame FSM states
//   err_code_e     - error cause reported on err_code
//   DEF_SYNC_BYTE  - default start-of-frame marker
//   byte_time_clks - clocks per UART byte (10 bit-times, truncated)
//   csum_xor       - one step of the 8-bit XOR checksum
// -----------------------------------------------------------------------------
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } frame_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
  localparam int unsigned BITS_PER_BYTE = 10;

  // Start + 8 data + stop bits, computed in 64 bits to avoid overflow.
  function automatic int unsigned byte_time_clks(input int unsigned clk_hz,
                                                 input int unsigned bitrate_bps);
    return 32'((64'(clk_hz) * 64'(BITS_PER_BYTE)) / 64'(bitrate_bps));
  endfunction

  function automatic logic [7:0] csum_xor(input logic [7:0] acc,
                                          input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Byte-in / frame-out bus of the UART frame controller.
//   rx_data/rx_valid            : byte stream from the UART receiver
//   frm_data/valid/last/ready   : payload handshake towards the consumer
//   frm_len                     : length of the frame being drained
//   frm_err/err_code            : error strobe and sticky cause
//   drop_cnt, busy              : status
// slave modport = controller view, master modport = producer/consumer view.
// -----------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if #(
  parameter int unsigned MAX_LEN = 16
);
  import uart_frame_pkg::*;

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       frm_data;
  logic             frm_valid;
  logic             frm_last;
  logic             frm_ready;
  logic [LEN_W-1:0] frm_len;
  logic             frm_err;
  err_code_e        err_code;
  logic [7:0]       drop_cnt;
  logic             busy;

  modport slave (
    input  rx_data, rx_valid, frm_ready,
    output frm_data, frm_valid, frm_last, frm_len, frm_err, err_code,
           drop_cnt, busy
  );

  modport master (
    output rx_data, rx_valid, frm_ready,
    input  frm_data, frm_valid, frm_last, frm_len, frm_err, err_code,
           drop_cnt, busy
  );

endinterface

// File: rtl/uart_gap_timer.sv
// -----------------------------------------------------------------------------
// uart_gap_timer
// Inter-byte timeout: loadable down-counter sized to GAP_BYTES byte-times.
//   clk, rst : clock, async active-high reset
//   clr      : reload the counter (a byte arrived); wins over en
//   en       : count while a frame is being collected
//   expired  : registered, high once the gap has elapsed while enabled
// -----------------------------------------------------------------------------
module uart_gap_timer
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 66_000_000,
  parameter int unsigned BITRATE_BPS = 9_600,
  parameter int unsigned GAP_BYTES   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned GAP_CLKS = GAP_BYTES * byte_time_clks(CLK_HZ, BITRATE_BPS);
  localparam int unsigned CNT_W    = (GAP_CLKS > 2) ? $clog2(GAP_CLKS) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GAP_CLKS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expired;

  // Reload on every byte; flag expiry one count before reaching zero so the
  // registered flag lines up with the end of the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (clr) begin
      r_cnt     <= LOAD_VAL;
      r_expired <= 1'b0;
    end else if (en) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      r_expired <= (r_cnt <= CNT_W'(1));
    end else begin
      r_expired <= 1'b0;
    end
  end

  assign expired = r_expired;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Frame controller behind the UART byte receiver: hunts for SYNC_BYTE,
// collects length + payload (+ XOR checksum when RX_FRAME_CHECKSUM_EN is
// defined), buffers the payload and drains whole frames only.
//   clk, rst : clock, async active-high reset
//   bus      : uart_rx_frame_ctrl_if.slave (rx byte in, frame handshake out,
//              frm_len, frm_err/err_code, drop_cnt, busy)
// Build option: `define RX_FRAME_CHECKSUM_EN adds the checksum byte/state.
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 66_000_000,
  parameter int unsigned BITRATE_BPS = 9_600,
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int unsigned GAP_BYTES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_frame_ctrl_if.slave   bus
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  frame_state_e     r_state;
  logic [LEN_W-1:0] r_frm_len;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [7:0]       r_buf [MAX_LEN];
  logic [7:0]       r_frm_data;
  logic             r_frm_valid;
  logic             r_frm_last;
  logic             r_frm_err;
  err_code_e        r_err_code;
  logic [7:0]       r_drop_cnt;
  logic             r_busy;
`ifdef RX_FRAME_CHECKSUM_EN
  logic [7:0]       r_acc;
`endif

  logic             w_tmr_en;
  logic             w_tmr_expired;
  logic             w_len_bad;
  logic             w_wr_last;
  logic             w_one_byte;
  logic             w_buf_we;
  logic [7:0]       w_first;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic             w_xfer;

  // Gap timer runs only while a frame is being collected.
  assign w_tmr_en = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) ||
                    (r_state == ST_CSUM);

  uart_gap_timer #(
    .CLK_HZ      (CLK_HZ),
    .BITRATE_BPS (BITRATE_BPS),
    .GAP_BYTES   (GAP_BYTES)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.rx_valid),
    .en      (w_tmr_en),
    .expired (w_tmr_expired)
  );

  assign w_len_bad  = (bus.rx_data == 8'd0) || (32'(bus.rx_data) > MAX_LEN);
  assign w_wr_last  = (LEN_W'(r_wptr) == (r_frm_len - LEN_W'(1)));
  assign w_one_byte = (r_frm_len == LEN_W'(1));
  assign w_buf_we   = (r_state == ST_PAYLOAD) && bus.rx_valid;
  assign w_rptr_nxt = r_rptr + PTR_W'(1);
  assign w_xfer     = r_frm_valid && bus.frm_ready;
  // Slot 0 is being written in the same cycle for a 1-byte frame: bypass it.
  assign w_first    = (r_wptr == '0) ? bus.rx_data : r_buf[0];

  // Payload buffer: plain storage, contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_wptr] <= bus.rx_data;
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_frm_len   <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_frm_data  <= 8'd0;
      r_frm_valid <= 1'b0;
      r_frm_last  <= 1'b0;
      r_frm_err   <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_drop_cnt  <= 8'd0;
      r_busy      <= 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
      r_acc       <= 8'd0;
`endif
    end else begin
      r_frm_err <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
            r_state <= ST_LEN;
            r_busy  <= 1'b1;
          end
        end

        ST_LEN: begin
          if (bus.rx_valid) begin
            if (w_len_bad) begin
              r_state    <= ST_HUNT;
              r_busy     <= 1'b0;
              r_frm_err  <= 1'b1;
              r_err_code <= ERR_LEN;
            end else begin
              r_state   <= ST_PAYLOAD;
              r_frm_len <= LEN_W'(bus.rx_data);
              r_wptr    <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
              r_acc     <= bus.rx_data;
`endif
            end
          end else if (w_tmr_expired) begin
            r_state    <= ST_HUNT;
            r_busy     <= 1'b0;
            r_frm_err  <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end
        end

        ST_PAYLOAD: begin
          if (bus.rx_valid) begin
`ifdef RX_FRAME_CHECKSUM_EN
            r_acc <= csum_xor(r_acc, bus.rx_data);
`endif
            if (w_wr_last) begin
`ifdef RX_FRAME_CHECKSUM_EN
              r_state     <= ST_CSUM;
`else
              r_state     <= ST_DRAIN;
              r_rptr      <= '0;
              r_frm_valid <= 1'b1;
              r_frm_data  <= w_first;
              r_frm_last  <= w_one_byte;
`endif
            end else begin
              r_wptr <= r_wptr + PTR_W'(1);
            end
          end else if (w_tmr_expired) begin
            r_state    <= ST_HUNT;
            r_busy     <= 1'b0;
            r_frm_err  <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end
        end

        ST_CSUM: begin
`ifdef RX_FRAME_CHECKSUM_EN
          if (bus.rx_valid) begin
            if (bus.rx_data == r_acc) begin
              r_state     <= ST_DRAIN;
              r_rptr      <= '0;
              r_frm_valid <= 1'b1;
              r_frm_data  <= r_buf[0];
              r_frm_last  <= w_one_byte;
            end else begin
              r_state    <= ST_HUNT;
              r_busy     <= 1'b0;
              r_frm_err  <= 1'b1;
              r_err_code <= ERR_CSUM;
            end
          end else if (w_tmr_expired) begin
            r_state    <= ST_HUNT;
            r_busy     <= 1'b0;
            r_frm_err  <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end
`else
          r_state <= ST_HUNT;
          r_busy  <= 1'b0;
`endif
        end

        ST_DRAIN: begin
          // Anything arriving now is discarded, sync bytes included.
          if (bus.rx_valid && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
          end
          if (w_xfer) begin
            if (r_frm_last) begin
              r_state     <= ST_HUNT;
              r_busy      <= 1'b0;
              r_frm_valid <= 1'b0;
              r_frm_last  <= 1'b0;
            end else begin
              r_rptr     <= w_rptr_nxt;
              r_frm_data <= r_buf[w_rptr_nxt];
              r_frm_last <= (LEN_W'(w_rptr_nxt) == (r_frm_len - LEN_W'(1)));
            end
          end
        end

        default: begin
          r_state <= ST_HUNT;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.frm_data  = r_frm_data;
  assign bus.frm_valid = r_frm_valid;
  assign bus.frm_last  = r_frm_last;
  assign bus.frm_len   = r_frm_len;
  assign bus.frm_err   = r_frm_err;
  assign bus.err_code  = r_err_code;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Directed bench for uart_rx_frame_ctrl. Clock scaled so one byte-time is
// 100 clocks (gap = 400 clocks). Checksum byte sent only when
// RX_FRAME_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;
  import uart_frame_pkg::*;

  localparam int unsigned CLK_HZ      = 96_000;
  localparam int unsigned BITRATE_BPS = 9_600;
  localparam int unsigned MAX_LEN     = 16;
  localparam int unsigned GAP_BYTES   = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  uart_rx_frame_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_rx_frame_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .BITRATE_BPS (BITRATE_BPS),
    .MAX_LEN     (MAX_LEN),
    .SYNC_BYTE   (8'hA5),
    .GAP_BYTES   (GAP_BYTES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: records transfers and error strobes away from the active edge.
  logic [7:0] beat_data [$];
  logic       beat_last [$];
  logic [4:0] beat_len;
  int         err_seen;
  logic [1:0] last_err;
  int         valid_cycles;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frm_valid) valid_cycles++;
      if (bus.frm_valid && bus.frm_ready) begin
        beat_data.push_back(bus.frm_data);
        beat_last.push_back(bus.frm_last);
        beat_len = bus.frm_len;
      end
      if (bus.frm_err) begin
        err_seen++;
        last_err = bus.err_code;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [7:0] d, input logic l);
    logic [8:0] obs;
    obs = 'x;
    if (i < beat_data.size()) obs = {beat_last[i], beat_data[i]};
    chk(tag, 32'(obs), 32'({l, d}));
  endtask

  task automatic clr_mon();
    beat_data.delete();
    beat_last.delete();
    beat_len     = '0;
    err_seen     = 0;
    last_err     = 2'd0;
    valid_cycles = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #2;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(bus.frm_data),  32'h0);
    chk({tag, "_valid"}, 32'(bus.frm_valid), 32'h0);
    chk({tag, "_last"},  32'(bus.frm_last),  32'h0);
    chk({tag, "_len"},   32'(bus.frm_len),   32'h0);
    chk({tag, "_err"},   32'(bus.frm_err),   32'h0);
    chk({tag, "_code"},  32'(bus.err_code),  32'h0);
    chk({tag, "_drop"},  32'(bus.drop_cnt),  32'h0);
    chk({tag, "_busy"},  32'(bus.busy),      32'h0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    clr_mon();
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.frm_ready = 1'b0;
    rst = 1'b1;
    idle(3);
    chk_all_zero("rst_hold");
    @(posedge clk); #2;
    rst = 1'b0;
    idle(2);
    chk_all_zero("rst_rel");

    // Valid 3-byte frame, consumer always ready.
    clr_mon();
    bus.frm_ready = 1'b1;
    send(8'h11);                       // not sync: ignored
    chk("hunt_ignore_busy", 32'(bus.busy), 32'h0);
    send(8'hA5);
    chk("sync_busy", 32'(bus.busy), 32'h1);
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
`ifdef RX_FRAME_CHECKSUM_EN
    send(8'h03);
`endif
    chk("f1_valid_rise", 32'(bus.frm_valid), 32'h1);
    chk("f1_first_data", 32'(bus.frm_data), 32'h11);
    idle(6);
    chk("f1_nbeats", 32'(beat_data.size()), 32'd3);
    chk_beat("f1_b0", 0, 8'h11, 1'b0);
    chk_beat("f1_b1", 1, 8'h22, 1'b0);
    chk_beat("f1_b2", 2, 8'h33, 1'b1);
    chk("f1_len", 32'(beat_len), 32'd3);
    chk("f1_valid_cycles", 32'(valid_cycles), 32'd3);
    chk("f1_no_err", 32'(err_seen), 32'd0);
    chk("f1_busy_end", 32'(bus.busy), 32'h0);

`ifdef RX_FRAME_CHECKSUM_EN
    // Same frame, wrong checksum.
    clr_mon();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    send(8'h04);
    chk("csum_err", 32'(bus.frm_err), 32'h1);
    chk("csum_code", 32'(bus.err_code), 32'h2);
    chk("csum_busy", 32'(bus.busy), 32'h0);
    idle(3);
    chk("csum_err_once", 32'(err_seen), 32'd1);
    chk("csum_no_valid", 32'(valid_cycles), 32'd0);
`endif

    // Length 0 and length 17 (> MAX_LEN).
    clr_mon();
    send(8'hA5); send(8'h00);
    chk("len0_err", 32'(bus.frm_err), 32'h1);
    chk("len0_code", 32'(bus.err_code), 32'h1);
    chk("len0_busy", 32'(bus.busy), 32'h0);
    idle(1);
    chk("len0_err_drop", 32'(bus.frm_err), 32'h0);
    send(8'hA5); send(8'h11);
    chk("len17_err", 32'(bus.frm_err), 32'h1);
    chk("len17_code", 32'(bus.err_code), 32'h1);
    idle(3);
    chk("len_err_count", 32'(err_seen), 32'd2);
    chk("len_no_valid", 32'(valid_cycles), 32'd0);

    // Inter-byte timeout after a partial frame.
    clr_mon();
    send(8'hA5); send(8'h02); send(8'h11);
    n = 0;
    while (!bus.frm_err && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("tmo_seen", 32'(bus.frm_err), 32'h1);
    chk("tmo_code", 32'(bus.err_code), 32'h3);
    chk("tmo_latency_window", 32'((n >= 399) && (n <= 401)), 32'h1);
    chk("tmo_busy", 32'(bus.busy), 32'h0);
    idle(2);
    chk("tmo_err_once", 32'(err_seen), 32'd1);
    chk("tmo_no_valid", 32'(valid_cycles), 32'd0);

    // Recovery frame after the timeout.
    clr_mon();
    send(8'hA5); send(8'h02); send(8'h5A); send(8'hC3);
`ifdef RX_FRAME_CHECKSUM_EN
    send(8'h9B);
`endif
    idle(5);
    chk("rec_nbeats", 32'(beat_data.size()), 32'd2);
    chk_beat("rec_b0", 0, 8'h5A, 1'b0);
    chk_beat("rec_b1", 1, 8'hC3, 1'b1);
    chk("rec_no_err", 32'(err_seen), 32'd0);

    // Back-pressure with bytes dropped during DRAIN.
    clr_mon();
    bus.frm_ready = 1'b0;
    send(8'hA5); send(8'h02); send(8'h77); send(8'h88);
`ifdef RX_FRAME_CHECKSUM_EN
    send(8'hFD);
`endif
    send(8'hA5); send(8'h01); send(8'h02);
    chk("bp_drop_cnt", 32'(bus.drop_cnt), 32'd3);
    chk("bp_hold_data", 32'(bus.frm_data), 32'h77);
    chk("bp_hold_valid", 32'(bus.frm_valid), 32'h1);
    chk("bp_hold_last", 32'(bus.frm_last), 32'h0);
    chk("bp_len", 32'(bus.frm_len), 32'd2);
    bus.frm_ready = 1'b1;
    idle(4);
    chk("bp_nbeats", 32'(beat_data.size()), 32'd2);
    chk_beat("bp_b0", 0, 8'h77, 1'b0);
    chk_beat("bp_b1", 1, 8'h88, 1'b1);
    chk("bp_busy_end", 32'(bus.busy), 32'h0);
    chk("bp_drop_keep", 32'(bus.drop_cnt), 32'd3);
    chk("bp_no_err", 32'(err_seen), 32'd0);

    // Reset in the middle of DRAIN.
    clr_mon();
    bus.frm_ready = 1'b0;
    send(8'hA5); send(8'h01); send(8'h99);
`ifdef RX_FRAME_CHECKSUM_EN
    send(8'h98);
`endif
    chk("mid_valid_pre", 32'(bus.frm_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(posedge clk); #2;
    rst = 1'b0;
    clr_mon();
    bus.frm_ready = 1'b1;
    send(8'hA5); send(8'h01); send(8'h42);
`ifdef RX_FRAME_CHECKSUM_EN
    send(8'h43);
`endif
    idle(4);
    chk("post_nbeats", 32'(beat_data.size()), 32'd1);
    chk_beat("post_b0", 0, 8'h42, 1'b1);
    chk("post_len", 32'(beat_len), 32'd1);
    chk("post_no_err", 32'(err_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
